count_tick_gen: RTL and testbench

Tick generator and run/step control that sits directly upstream of the 8-bit LED counter and drives its count enable. It turns the board clock into a slow, human-visible count rate. It also takes two raw push-buttons, run and step: run toggles free-running counting, and step advances the counter by exactly one while it is paused.

---
 rtl/count_tick_pkg.sv | 12 +
 rtl/btn_debounce.sv | 57 +++++
 rtl/count_tick_gen.sv | 80 ++++++++
 tb/tb_count_tick_gen.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/count_tick_pkg.sv
// Shared state encoding and default timing constants for the LED count tick generator.
package count_tick_pkg;

    typedef enum logic {
        ST_PAUSED  = 1'b0,
        ST_RUNNING = 1'b1
    } state_e;

    localparam int DIV_DEFAULT        = 50_000_000;
    localparam int DEB_CYCLES_DEFAULT = 1_000_000;

endpackage

// File: rtl/btn_debounce.sv
// Raw push-button to single press pulse: 2-FF synchronizer, stable-level debouncer,
// and a rising-edge detector on the debounced level.
module btn_debounce #(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q;
    logic          level_d;
    logic          press_q;
    logic          press_d;
    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Any cycle where the synchronized input agrees with the accepted level restarts the count,
    // so only an unbroken run of disagreement can flip the level.
    always_comb begin
        level_d = level_q;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CNT_MAX) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        press_d = level_d & ~level_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/count_tick_gen.sv
// Run/step controller and prescaler producing the count-enable tick for the LED counter.
module count_tick_gen
    import count_tick_pkg::*;
#(
    parameter int DIV        = DIV_DEFAULT,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_run,
    input  logic btn_step,
    output logic tick,
    output logic running
);

    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PRESC_MAX = PW'(DIV - 1);

    logic          runPress;
    logic          stepPress;
    state_e        state_q;
    logic [PW-1:0] presc_q;
    logic          tick_q;
    logic          running_q;

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_run_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_run),
        .press   (runPress)
    );

    btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_step_deb (
        .clk     (clk),
        .rst     (rst),
        .btn_raw (btn_step),
        .press   (stepPress)
    );

    // A run press always takes priority: it swallows a coincident step press and
    // cancels a tick that the prescaler wrap would otherwise have produced.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_PAUSED;
            presc_q   <= '0;
            tick_q    <= 1'b0;
            running_q <= 1'b0;
        end else begin
            tick_q  <= 1'b0;
            presc_q <= '0;
            case (state_q)
                ST_PAUSED: begin
                    if (runPress) begin
                        state_q   <= ST_RUNNING;
                        running_q <= 1'b1;
                    end else if (stepPress) begin
                        tick_q <= 1'b1;
                    end
                end
                ST_RUNNING: begin
                    if (runPress) begin
                        state_q   <= ST_PAUSED;
                        running_q <= 1'b0;
                    end else begin
                        tick_q  <= (presc_q == PRESC_MAX);
                        presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_PAUSED;
                    running_q <= 1'b0;
                end
            endcase
        end
    end

    assign tick    = tick_q;
    assign running = running_q;

endmodule

// File: tb/tb_count_tick_gen.sv
// Scoreboard bench for count_tick_gen with DIV=4, DEB_CYCLES=3: per-cycle expected
// {running,tick} values are queued from the timing rules and compared on the falling edge.
module tb_count_tick_gen;

    typedef struct {
        int    cyc;
        logic  runExp;
        logic  tickExp;
        string tag;
    } exp_t;

    logic clk;
    logic rst;
    logic btnRun;
    logic btnStep;
    logic tick;
    logic running;

    int   cyc;
    int   total;
    int   bad;
    int   b;
    int   e;
    exp_t expQ[$];
    exp_t ent;

    count_tick_gen #(.DIV(4), .DEB_CYCLES(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_run  (btnRun),
        .btn_step (btnStep),
        .tick     (tick),
        .running  (running)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Edge counter: at a falling edge, cyc names the rising edge just taken.
    initial cyc = 0;
    always @(posedge clk) cyc++;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        total++;
        if (actual !== expected) begin
            bad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
        end
    endtask

    // Queue the expected outputs for cycles from..to; firstTick<0 means no tick,
    // period 0 means a single tick at firstTick.
    task automatic expectWindow(input int from, input int to, input logic runVal,
                                input int firstTick, input int period, input string tag);
        for (int c = from; c <= to; c++) begin
            exp_t x;
            logic t;
            t = 1'b0;
            if (firstTick >= 0 && c >= firstTick) begin
                if (period == 0) t = (c == firstTick);
                else             t = ((c - firstTick) % period) == 0;
            end
            x.cyc     = c;
            x.runExp  = runVal;
            x.tickExp = t;
            x.tag     = tag;
            expQ.push_back(x);
        end
    endtask

    always @(negedge clk) begin
        while (expQ.size() > 0 && expQ[0].cyc <= cyc) begin
            ent = expQ.pop_front();
            checkOutput($sformatf("%s@%0d", ent.tag, ent.cyc), {30'd0, running, tick},
                        {30'd0, ent.runExp, ent.tickExp});
        end
    end

    task automatic waitUntil(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic waitDrain();
        int n;
        n = 0;
        while (expQ.size() > 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain", expQ.size(), 0);
        expQ.delete();
    endtask

    task automatic doReset();
        rst     = 1'b1;
        btnRun  = 1'b0;
        btnStep = 1'b0;
        expectWindow(cyc + 1, cyc + 1, 1'b0, -1, 0, "reset");
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic applyStimulus();
        // Buttons held through a 10-cycle reset: run and step press together on release, run wins.
        b = cyc + 1;
        e = b + 10;
        btnRun  = 1'b1;
        btnStep = 1'b1;
        expectWindow(b, e + 5, 1'b0, -1, 0, "rstHeld");
        expectWindow(e + 6, e + 20, 1'b1, e + 10, 4, "rstRelease");
        waitUntil(b + 9);
        rst = 1'b0;
        waitUntil(e + 20);
        btnRun  = 1'b0;
        btnStep = 1'b0;
        waitDrain();

        // Clean run press held 20 cycles.
        doReset();
        b = cyc + 1;
        expectWindow(b, b + 5, 1'b0, -1, 0, "runDeb");
        expectWindow(b + 6, b + 30, 1'b1, b + 10, 4, "runTicks");
        btnRun = 1'b1;
        waitUntil(b + 19);
        btnRun = 1'b0;
        waitDrain();

        // Bouncy run input: two high, two low, never stable long enough.
        doReset();
        b = cyc + 1;
        expectWindow(b, b + 40, 1'b0, -1, 0, "bounce");
        for (int i = 0; i < 30; i++) begin
            btnRun = ((i / 2) % 2) == 0;
            @(negedge clk);
        end
        btnRun = 1'b0;
        waitDrain();

        // Step presses while paused: one tick per press, no auto-repeat.
        doReset();
        b = cyc + 1;
        expectWindow(b, b + 27, 1'b0, b + 6, 0, "step1");
        expectWindow(b + 28, b + 40, 1'b0, b + 34, 0, "step2");
        btnStep = 1'b1;
        waitUntil(b + 19);
        btnStep = 1'b0;
        waitUntil(b + 27);
        btnStep = 1'b1;
        waitUntil(b + 35);
        btnStep = 1'b0;
        waitDrain();

        // Pause press lands with prescaler at DIV-1, then a restart.
        doReset();
        b = cyc + 1;
        expectWindow(b, b + 5, 1'b0, -1, 0, "startA");
        expectWindow(b + 6, b + 17, 1'b1, b + 10, 4, "runA");
        expectWindow(b + 18, b + 29, 1'b0, -1, 0, "pauseWrap");
        expectWindow(b + 30, b + 40, 1'b1, b + 34, 4, "restart");
        btnRun = 1'b1;
        waitUntil(b + 4);
        btnRun = 1'b0;
        waitUntil(b + 11);
        btnRun = 1'b1;
        waitUntil(b + 16);
        btnRun = 1'b0;
        waitUntil(b + 23);
        btnRun = 1'b1;
        waitUntil(b + 28);
        btnRun = 1'b0;
        waitDrain();

        // One-cycle reset mid-count, then the prescaler restarts from zero.
        doReset();
        b = cyc + 1;
        expectWindow(b, b + 5, 1'b0, -1, 0, "startB");
        expectWindow(b + 6, b + 11, 1'b1, b + 10, 4, "runB");
        expectWindow(b + 12, b + 21, 1'b0, -1, 0, "midReset");
        expectWindow(b + 22, b + 32, 1'b1, b + 26, 4, "afterReset");
        btnRun = 1'b1;
        waitUntil(b + 4);
        btnRun = 1'b0;
        waitUntil(b + 11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        waitUntil(b + 15);
        btnRun = 1'b1;
        waitUntil(b + 20);
        btnRun = 1'b0;
        waitDrain();
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        btnRun  = 1'b0;
        btnStep = 1'b0;
        @(negedge clk);
        applyStimulus();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #50000;
        $display("[TB] FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
